// File: rtl/step_pkg.sv
// Shared types and constants for the stepper sequencer: FSM states, coil phase
// table and phase-index step sizes.
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Packed so that PHASE_TABLE[i] selects entry i (entry 0 is rightmost).
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  localparam logic [2:0] STEP_HALF = 3'd1;
  localparam logic [2:0] STEP_FULL = 3'd2;

  function automatic logic [2:0] next_phase(input logic [2:0] ph,
                                            input logic       fwd,
                                            input logic       half);
    logic [2:0] delta;
    delta = half ? STEP_HALF : STEP_FULL;
    return fwd ? (ph + delta) : (ph - delta);
  endfunction

endpackage

// File: rtl/step_seq_ctrl_edge_det.sv
// Rising-edge detector for the step-rate clock; history resets high so a level
// already high at reset release does not count as an edge.
module edge_det (
  input  logic clk_25M,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  always_comb begin
    prev_d = d;
  end

  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/step_seq_ctrl.sv
// Stepper motor move sequencer: accepts a move command, steps the coil phase
// table on each step event, holds the coils briefly, then de-energizes.
//
// state | meaning
// IDLE  | coils off, cmd_ready high, phase index retained
// RUN   | stepping; one phase/pos update per step event until count reaches 0
// HOLD  | coils held at last pattern for HOLD_TICKS step events
module step_seq_ctrl
  import step_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned POS_W      = 16
) (
  input  logic             clk_25M,
  input  logic             reset,
  input  logic             clk_step,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [15:0]      cmd_steps,
  input  logic             cmd_half,
  input  logic             abort,
  output logic [3:0]       coil,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] pos
);

  localparam logic [15:0]      HOLD_LOAD = 16'(HOLD_TICKS);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

  state_e            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [15:0]       rem_q, rem_d;
  logic [15:0]       hold_q, hold_d;
  logic              dir_q, dir_d;
  logic              half_q, half_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              step_ev;

  edge_det u_edge_det (
    .clk_25M (clk_25M),
    .reset   (reset),
    .d       (clk_step),
    .rise    (step_ev)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pos_d     = pos_q;
    rem_d     = rem_q;
    hold_d    = hold_q;
    dir_d     = dir_q;
    half_d    = half_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_d  = cmd_dir;
          half_d = cmd_half;
          rem_d  = cmd_steps;
          if (cmd_steps == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        // Abort wins over a coincident step event: nothing moves this cycle.
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          rem_d     = 16'd0;
        end else if (step_ev) begin
          phase_d = next_phase(phase_q, dir_q, half_q);
          pos_d   = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
          rem_d   = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            if (HOLD_LOAD == 16'd0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_HOLD;
              hold_d  = HOLD_LOAD;
            end
          end
        end
      end

      ST_HOLD: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          hold_d    = 16'd0;
        end else if (step_ev) begin
          hold_d = hold_q - 16'd1;
          if (hold_q == 16'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_25M or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= 3'd0;
      pos_q     <= '0;
      rem_q     <= 16'd0;
      hold_q    <= 16'd0;
      dir_q     <= 1'b0;
      half_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      rem_q     <= rem_d;
      hold_q    <= hold_d;
      dir_q     <= dir_d;
      half_q    <= half_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign coil      = busy ? PHASE_TABLE[phase_q] : 4'b0000;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign pos       = pos_q;

endmodule

// File: tb/tb_step_seq_ctrl.sv
// Self-checking bench for step_seq_ctrl: table of consecutive moves with a
// per-step scoreboard, plus abort, wrap and mid-move reset sequences.
module tb_step_seq_ctrl;

  logic        clk_25M = 1'b0;
  logic        reset = 1'b0;
  logic        clk_step = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = 16'd0;
  logic        cmd_half = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_ready;
  logic [3:0]  coil;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] pos;

  always #5 clk_25M = ~clk_25M;

  step_seq_ctrl #(.HOLD_TICKS(4), .POS_W(16)) dut (
    .clk_25M   (clk_25M),
    .reset     (reset),
    .clk_step  (clk_step),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_half  (cmd_half),
    .abort     (abort),
    .coil      (coil),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .pos       (pos)
  );

  typedef struct {
    logic [3:0]  coil;
    logic [15:0] pos;
  } exp_t;

  typedef struct {
    logic        dir;
    logic        half;
    logic [15:0] steps;
    logic [3:0]  exp_coil;
    logic [15:0] exp_pos;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[5];
  logic [3:0]  ph_tab[8];
  int          m_phase = 0;
  logic [15:0] m_pos = 16'd0;
  bit          sb_on = 1'b1;
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          done_cnt = 0;
  int          abt_cnt = 0;

  always @(negedge clk_25M) begin
    if (done) done_cnt++;
    if (aborted) abt_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_25M);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; clk_step = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    m_phase = 0; m_pos = 16'd0; sb_q.delete();
  endtask

  // Handshake with a clk_step rise in the same cycle, which must not step.
  // Returns just after the accepting edge with clk_step low.
  task automatic send(input logic d, input logic h, input logic [15:0] n);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin tick(); w++; end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_dir = d; cmd_half = h; cmd_steps = n; clk_step = 1'b1;
    tick();
    cmd_valid = 1'b0; clk_step = 1'b0;
  endtask

  // One step event while running: model pushes the expectation, DUT output pops it.
  task automatic step_run(input logic d, input logic h);
    exp_t e;
    m_phase = (m_phase + (d ? (h ? 1 : 2) : (h ? 7 : 6))) % 8;
    m_pos   = d ? m_pos + 16'd1 : m_pos - 16'd1;
    if (sb_on) begin
      e.coil = ph_tab[m_phase]; e.pos = m_pos;
      sb_q.push_back(e);
    end
    clk_step = 1'b1;
    tick();
    clk_step = 1'b0;
    if (sb_on) begin
      e = sb_q.pop_front();
      chk("step_coil", coil, e.coil);
      chk("step_pos", pos, e.pos);
    end
    tick();
  endtask

  task automatic step_idle();
    clk_step = 1'b1; tick(); clk_step = 1'b0; tick();
  endtask

  task automatic hold_out(input logic [3:0] exp_coil);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) step_idle();
    chk("hold_coil", coil, exp_coil);
    chk("hold_busy", busy, 1);
    chk("no_early_done", done_cnt, d0);
    clk_step = 1'b1;
    tick();
    clk_step = 1'b0;
    chk("done_pulse", done, 1);
    chk("idle_coil", coil, 4'b0000);
    chk("ready_after", cmd_ready, 1);
    tick();
    chk("done_once", done_cnt, d0 + 1);
  endtask

  initial begin
    int d0;
    int a0;
    ph_tab = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    vecs[0] = '{1'b1, 1'b1, 16'd3, 4'b0110, 16'd3};
    vecs[1] = '{1'b0, 1'b1, 16'd3, 4'b1000, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 16'd2, 4'b0010, 16'hFFFE};
    vecs[3] = '{1'b1, 1'b0, 16'd5, 4'b0001, 16'd3};
    vecs[4] = '{1'b1, 1'b1, 16'd0, 4'b0000, 16'd3};

    #2;
    chk("rst_coil", coil, 4'b0000);
    chk("rst_pos", pos, 16'd0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    do_reset();
    chk("rst_ready", cmd_ready, 1);

    // Consecutive moves; phase index carries over between them.
    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt;
      send(vecs[v].dir, vecs[v].half, vecs[v].steps);
      if (vecs[v].steps == 16'd0) begin
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_coil", coil, 4'b0000);
        tick();
        chk("zero_done_once", done_cnt, d0 + 1);
        chk("zero_pos", pos, vecs[v].exp_pos);
      end else begin
        chk("accept_busy", busy, 1);
        chk("accept_ready", cmd_ready, 0);
        chk("accept_coil", coil, ph_tab[m_phase]);
        chk("accept_pos", pos, m_pos);
        tick();
        cmd_valid = 1'b1;  // must be ignored while busy
        cmd_steps = 16'd9;
        for (int s = 0; s < int'(vecs[v].steps); s++) step_run(vecs[v].dir, vecs[v].half);
        cmd_valid = 1'b0;
        chk("move_coil", coil, vecs[v].exp_coil);
        chk("move_pos", pos, vecs[v].exp_pos);
        hold_out(vecs[v].exp_coil);
      end
    end

    // Abort coincident with the 2nd step event of a 5-step move.
    do_reset();
    send(1'b1, 1'b1, 16'd5);
    tick();
    step_run(1'b1, 1'b1);
    a0 = abt_cnt; d0 = done_cnt;
    abort = 1'b1; clk_step = 1'b1;
    tick();
    abort = 1'b0; clk_step = 1'b0;
    chk("abort_pos", pos, 16'd1);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_coil", coil, 4'b0000);
    tick();
    chk("abort_pulse", abt_cnt, a0 + 1);
    chk("abort_no_done", done_cnt, d0);
    abort = 1'b1; tick(); tick(); abort = 1'b0;
    chk("idle_abort_ignored", abt_cnt, a0 + 1);
    send(1'b1, 1'b1, 16'd1);
    tick();
    step_run(1'b1, 1'b1);
    chk("resume_phase_coil", coil, 4'b0100);
    hold_out(4'b0100);

    // Positive wrap: 32767 forward steps, then one more.
    do_reset();
    sb_on = 1'b0;
    send(1'b1, 1'b0, 16'd32767);
    tick();
    for (int s = 0; s < 32767; s++) step_run(1'b1, 1'b0);
    sb_on = 1'b1;
    chk("pos_max", pos, 16'h7FFF);
    hold_out(ph_tab[m_phase]);
    send(1'b1, 1'b0, 16'd1);
    tick();
    step_run(1'b1, 1'b0);
    chk("pos_wrap", pos, 16'h8000);
    hold_out(ph_tab[m_phase]);

    // Reset mid-RUN, released while clk_step is high.
    send(1'b1, 1'b1, 16'd5);
    tick();
    step_run(1'b1, 1'b1);
    step_run(1'b1, 1'b1);
    d0 = done_cnt; a0 = abt_cnt;
    clk_step = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_coil", coil, 4'b0000);
    chk("mid_rst_pos", pos, 16'd0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_aborted", aborted, 0);
    tick(); tick();
    reset = 1'b1;
    m_phase = 0; m_pos = 16'd0;
    tick();
    chk("rel_ready", cmd_ready, 1);
    send(1'b1, 1'b1, 16'd2);
    clk_step = 1'b1;
    tick();
    chk("rel_no_step_pos", pos, 16'd0);
    chk("rel_no_step_coil", coil, 4'b1000);
    clk_step = 1'b0;
    tick();
    step_run(1'b1, 1'b1);
    step_run(1'b1, 1'b1);
    chk("rel_no_pulses", done_cnt + abt_cnt, d0 + a0);
    hold_out(4'b0100);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: timeout at %0t, %0d/%0d checks passed", $time, pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
